// File: rtl/mtm_alu_pkg.sv
// Shared types, constants and frame helpers for the MTM ALU serial output stage.
package mtm_alu_pkg;

  localparam int unsigned FRAME_BITS  = 11;
  localparam int unsigned DATA_FRAMES = 4;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned C_W         = 32;
  localparam int unsigned FLG_W       = 4;
  localparam int unsigned CRC_W       = 3;
  localparam int unsigned ERR_W       = 3;
  localparam int unsigned FCNT_W      = 3;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic CTL_DATA  = 1'b0;
  localparam logic CTL_CMD   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FRAME = 2'b01
  } state_t;

  typedef logic [FRAME_BITS-1:0] frame_t;

  typedef struct packed {
    logic [C_W-1:0]    c;
    logic [BYTE_W-1:0] ctl_byte;
  } payload_t;

  function automatic frame_t build_frame(input logic ctl, input logic [BYTE_W-1:0] data);
    return {START_BIT, ctl, data, STOP_BIT};
  endfunction

  // Error CTL byte: trailing bit is even parity of the leading seven, always 1 here.
  function automatic logic [BYTE_W-1:0] err_byte(input logic [ERR_W-1:0] err);
    return {1'b1, err, err, 1'b1};
  endfunction

  function automatic logic [BYTE_W-1:0] data_ctl_byte(input logic [FLG_W-1:0] flg,
                                                      input logic [CRC_W-1:0] crc);
    return {1'b0, flg, crc};
  endfunction

  function automatic logic [BYTE_W-1:0] data_byte(input logic [C_W-1:0] c,
                                                  input logic [FCNT_W-1:0] idx);
    case (idx)
      3'd0:    return c[31:24];
      3'd1:    return c[23:16];
      3'd2:    return c[15:8];
      default: return c[7:0];
    endcase
  endfunction

endpackage

// File: rtl/mtm_alu_serializer_if.sv
// Request/result bus between the ALU core and the serializer, plus the serial line.
interface mtm_alu_serializer_if;
  import mtm_alu_pkg::*;

  logic             send_data;
  logic [C_W-1:0]   C_in;
  logic [FLG_W-1:0] flg_in;
  logic [CRC_W-1:0] crc_in;
  logic             err_valid;
  logic [ERR_W-1:0] err_in;
  logic             sout;
  logic             busy;

  modport master (output send_data, C_in, flg_in, crc_in, err_valid, err_in,
                  input  sout, busy);
  modport slave  (input  send_data, C_in, flg_in, crc_in, err_valid, err_in,
                  output sout, busy);
endinterface

// File: rtl/mtm_alu_frame_tx.sv
// Single-frame shifter: sends one 11-bit frame MSB first, each bit held BIT_CYCLES clocks.
module mtm_alu_frame_tx
  import mtm_alu_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clear,
  input  logic   load,
  input  frame_t frame,
  output logic   sout,
  output logic   done_c
);

  localparam int unsigned PW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned BW = $clog2(FRAME_BITS);

  logic [PW-1:0] presc;
  logic [BW-1:0] bit_cnt;
  frame_t        shreg;
  logic          active;
  logic          bit_end_c;

  assign bit_end_c = active && (presc == PW'(BIT_CYCLES - 1));
  assign done_c    = bit_end_c && (bit_cnt == BW'(FRAME_BITS - 1));

  // A load on the done edge chains the next frame with no idle bit in between.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      presc   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      active  <= 1'b0;
      sout    <= STOP_BIT;
    end else if (load) begin
      presc   <= '0;
      bit_cnt <= '0;
      shreg   <= {frame[FRAME_BITS-2:0], 1'b0};
      active  <= 1'b1;
      sout    <= frame[FRAME_BITS-1];
    end else if (done_c) begin
      presc   <= '0;
      bit_cnt <= '0;
      active  <= 1'b0;
      sout    <= STOP_BIT;
    end else if (bit_end_c) begin
      presc   <= '0;
      bit_cnt <= bit_cnt + BW'(1);
      shreg   <= shreg << 1;
      sout    <= shreg[FRAME_BITS-1];
    end else if (active) begin
      presc   <= presc + PW'(1);
    end
  end

endmodule

// File: rtl/mtm_alu_serializer.sv
// MTM ALU output stage: packet FSM that latches a result or error report and streams its frames.
module mtm_alu_serializer
  import mtm_alu_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  mtm_alu_serializer_if.slave bus
);

  state_t            state;
  logic [FCNT_W-1:0] frame_cnt;
  logic [FCNT_W-1:0] last_frame;
  payload_t          pay;
  logic              busy;
  logic              sout;

  logic              load_c;
  logic              clear_c;
  logic              done_c;
  frame_t            frame_c;
  logic [FCNT_W-1:0] next_idx_c;

  // Frame to hand the shifter: first frame straight from the inputs, later ones from the latch.
  always_comb begin
    load_c     = 1'b0;
    clear_c    = 1'b0;
    next_idx_c = frame_cnt + FCNT_W'(1);
    frame_c    = build_frame(CTL_CMD, pay.ctl_byte);
    case (state)
      ST_IDLE: begin
        if (bus.err_valid) begin
          load_c  = 1'b1;
          frame_c = build_frame(CTL_CMD, err_byte(bus.err_in));
        end else if (bus.send_data) begin
          load_c  = 1'b1;
          frame_c = build_frame(CTL_DATA, bus.C_in[31:24]);
        end
      end
      ST_FRAME: begin
        if (done_c && (frame_cnt != last_frame)) begin
          load_c = 1'b1;
          if (next_idx_c == FCNT_W'(DATA_FRAMES))
            frame_c = build_frame(CTL_CMD, pay.ctl_byte);
          else
            frame_c = build_frame(CTL_DATA, data_byte(pay.c, next_idx_c));
        end
      end
      default: clear_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      frame_cnt  <= '0;
      last_frame <= '0;
      pay        <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.err_valid) begin
            pay.ctl_byte <= err_byte(bus.err_in);
            last_frame   <= '0;
            frame_cnt    <= '0;
            busy         <= 1'b1;
            state        <= ST_FRAME;
          end else if (bus.send_data) begin
            pay.c        <= bus.C_in;
            pay.ctl_byte <= data_ctl_byte(bus.flg_in, bus.crc_in);
            last_frame   <= FCNT_W'(DATA_FRAMES);
            frame_cnt    <= '0;
            busy         <= 1'b1;
            state        <= ST_FRAME;
          end
        end
        ST_FRAME: begin
          if (done_c) begin
            if (frame_cnt == last_frame) begin
              frame_cnt <= '0;
              busy      <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              frame_cnt <= next_idx_c;
            end
          end
        end
        default: begin
          frame_cnt <= '0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  mtm_alu_frame_tx #(.BIT_CYCLES(BIT_CYCLES)) u_frame_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear_c),
    .load   (load_c),
    .frame  (frame_c),
    .sout   (sout),
    .done_c (done_c)
  );

  assign bus.sout = sout;
  assign bus.busy = busy;

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Scoreboard bench for mtm_alu_serializer at BIT_CYCLES=1 and BIT_CYCLES=4.
module tb_mtm_alu_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mtm_alu_serializer_if bus1 ();
  mtm_alu_serializer_if bus4 ();

  mtm_alu_serializer #(.BIT_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mtm_alu_serializer #(.BIT_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  // Expected traffic per DUT: packet lengths (frames) and the frames themselves.
  int          pkt_q   [2][$];
  logic [10:0] frame_q [2][$];
  int          free_at [2];

  bit          act [2];
  bit          skip [2];
  bit          pend [2];
  bit          idle_bad [2];
  int          k [2];
  int          nfr [2];
  int          ferr [2];
  logic [10:0] cur [2];
  logic [10:0] gotf [2];

  function automatic int bc(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic get_busy(input int d);
    return (d == 0) ? bus1.busy : bus4.busy;
  endfunction

  function automatic logic get_sout(input int d);
    return (d == 0) ? bus1.sout : bus4.sout;
  endfunction

  task automatic chk(input string name, input int d, input bit ok,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s dut%0d got=%h expected=%h at cycle %0d", name, d, got, exp, cyc);
    end
  endtask

  function automatic logic [10:0] mk(input logic ctl, input logic [7:0] b);
    logic [10:0] f;
    f[10] = 1'b0;
    f[9]  = ctl;
    for (int i = 0; i < 8; i++) f[8 - i] = b[7 - i];
    f[0]  = 1'b1;
    return f;
  endfunction

  task automatic model_push(input int d, input bit is_err, input logic [31:0] c,
                            input logic [3:0] f, input logic [2:0] cr, input logic [2:0] er);
    logic [6:0] head;
    if (is_err) begin
      head = {1'b1, er, er};
      pkt_q[d].push_back(1);
      frame_q[d].push_back(mk(1'b1, {head, ^head}));
    end else begin
      pkt_q[d].push_back(5);
      for (int i = 0; i < 4; i++) frame_q[d].push_back(mk(1'b0, 8'((c >> (24 - 8 * i)) & 32'hFF)));
      frame_q[d].push_back(mk(1'b1, {1'b0, f, cr}));
    end
  endtask

  task automatic drive(input int d, input logic ev, input logic sd, input logic [31:0] c,
                       input logic [3:0] f, input logic [2:0] cr, input logic [2:0] er);
    if (d == 0) begin
      bus1.err_valid = ev; bus1.send_data = sd; bus1.C_in = c;
      bus1.flg_in = f; bus1.crc_in = cr; bus1.err_in = er;
    end else begin
      bus4.err_valid = ev; bus4.send_data = sd; bus4.C_in = c;
      bus4.flg_in = f; bus4.crc_in = cr; bus4.err_in = er;
    end
  endtask

  // Issue a one-cycle request; predict acceptance from the bench's own notion of when the line frees.
  task automatic request(input int d, input bit ev, input bit sd, input logic [31:0] c,
                         input logic [3:0] f, input logic [2:0] cr, input logic [2:0] er,
                         input bit now);
    int e;
    bit acc;
    if (!now) @(negedge clk);
    drive(d, ev, sd, c, f, cr, er);
    e = cyc + 1;
    acc = (ev || sd) && (e > free_at[d]);
    if (acc) begin
      model_push(d, ev, c, f, cr, er);
      free_at[d] = e + (ev ? 1 : 5) * 11 * bc(d);
    end
    @(negedge clk);
    drive(d, 1'b0, 1'b0, $urandom, 4'($urandom), 3'($urandom), 3'($urandom));
    if (acc)
      chk("accept_latency", d, get_busy(d) === 1'b1 && get_sout(d) === 1'b0,
          {30'd0, get_busy(d), get_sout(d)}, 32'h2);
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    @(negedge clk);
    while (get_busy(d) !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", d, n < 3000, n, 3000);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk("reset_state", d, get_sout(d) === 1'b1 && get_busy(d) === 1'b0,
          {30'd0, get_sout(d), get_busy(d)}, 32'h2);
    repeat (hold - 1) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      pkt_q[d].delete();
      frame_q[d].delete();
      free_at[d] = 0;
    end
    rst_n = 1'b1;
  endtask

  // Monitor: one sample per DUT per cycle, compared bit-for-bit against the expected frames.
  task automatic mon_step(input int d, input logic so, input logic bz);
    int j;
    if (!rst_n) begin
      act[d] = 0; pend[d] = 0; skip[d] = 0;
      return;
    end
    if (pend[d]) begin
      pend[d] = 0;
      chk("busy_fall", d, bz === 1'b0 && so === 1'b1, {30'd0, bz, so}, 32'h1);
    end
    if (skip[d] && bz !== 1'b1) skip[d] = 0;
    if (!act[d] && !skip[d]) begin
      if (bz === 1'b1) begin
        if (pkt_q[d].size() == 0) begin
          chk("unexpected_packet", d, 1'b0, 1, 0);
          skip[d] = 1;
        end else begin
          nfr[d] = pkt_q[d].pop_front();
          act[d] = 1; k[d] = 0; ferr[d] = 0;
        end
      end else if (so !== 1'b1) begin
        idle_bad[d] = 1;
      end
    end
    if (act[d]) begin
      j = k[d] / bc(d);
      if (k[d] % bc(d) == 0) begin
        if (j % 11 == 0) cur[d] = (frame_q[d].size() > 0) ? frame_q[d].pop_front() : 11'h7FF;
        gotf[d] = {gotf[d][9:0], so};
      end
      if (so !== cur[d][10 - (j % 11)] || bz !== 1'b1) ferr[d]++;
      k[d]++;
      if (k[d] % (11 * bc(d)) == 0) begin
        chk("frame", d, ferr[d] == 0, {21'd0, gotf[d]}, {21'd0, cur[d]});
        ferr[d] = 0;
        if (k[d] == nfr[d] * 11 * bc(d)) begin
          act[d] = 0;
          pend[d] = 1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, bus1.sout, bus1.busy);
    mon_step(1, bus4.sout, bus4.busy);
  end

  initial begin
    int kind;
    for (int d = 0; d < 2; d++) drive(d, 1'b0, 1'b0, '0, '0, '0, '0);
    do_reset(5);
    repeat (10) @(negedge clk);

    // Directed data packet, then error packets (alone and colliding with send_data).
    request(0, 1'b0, 1'b1, 32'h12345678, 4'b0000, 3'b011, 3'b000, 1'b0);
    wait_idle(0);
    request(0, 1'b1, 1'b0, $urandom, 4'($urandom), 3'($urandom), 3'b100, 1'b0);
    wait_idle(0);
    request(0, 1'b1, 1'b1, $urandom, 4'($urandom), 3'($urandom), 3'b100, 1'b0);
    wait_idle(0);

    // Request mid-packet and on the busy-falling edge are dropped; the next edge is accepted.
    request(0, 1'b0, 1'b1, 32'hA5C3_0F96, 4'b1001, 3'b110, 3'b000, 1'b0);
    repeat (19) @(negedge clk);
    request(0, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b1111, 3'b111, 3'b000, 1'b1);
    while (cyc + 1 < free_at[0]) @(negedge clk);
    request(0, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b0101, 3'b001, 3'b000, 1'b1);
    request(0, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b0101, 3'b001, 3'b000, 1'b1);
    wait_idle(0);

    request(1, 1'b0, 1'b1, 32'h0, 4'b0010, 3'b101, 3'b000, 1'b0);
    wait_idle(1);

    // Reset during frame 2 aborts the packet; a clean packet follows.
    request(0, 1'b0, 1'b1, $urandom, 4'($urandom), 3'($urandom), 3'b000, 1'b0);
    repeat (25) @(negedge clk);
    do_reset(2);
    request(0, 1'b0, 1'b1, $urandom, 4'($urandom), 3'($urandom), 3'b000, 1'b0);
    wait_idle(0);

    for (int d = 0; d < 2; d++) begin
      for (int it = 0; it < 30; it++) begin
        kind = $urandom_range(0, 3);
        repeat ($urandom_range(0, 70)) @(negedge clk);
        request(d, kind == 1 || kind == 2, kind == 0 || kind == 2, $urandom,
                4'($urandom), 3'($urandom), 3'($urandom), 1'b0);
      end
      wait_idle(d);
    end

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("queue_drained", d, pkt_q[d].size() == 0 && frame_q[d].size() == 0 && !act[d],
          pkt_q[d].size(), 0);
      chk("idle_high", d, !idle_bad[d], {31'd0, idle_bad[d]}, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
